// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module  : mem_arbiter_pkg
// Purpose : Shared encodings and defaults for the IF/LS memory arbiter.
//           Holds the state encodings (ST_IDLE/ST_BUSY), the owner encodings
//           (OWN_IF/OWN_LS), default geometry and a counter-width helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  // Arbiter states: a request is only ever sampled in ST_IDLE.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Owner of the in-flight access (also the round-robin history).
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

  localparam int ARB_DEF_AW      = 16;
  localparam int ARB_DEF_DW      = 16;
  localparam int ARB_DEF_TIMEOUT = 15;

  // Bits needed to hold a count of 0..limit.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
// ============================================================================
// Module  : rr_pick2
// Purpose : Combinational two-way round-robin pick between the instruction
//           fetch and load/store requesters.
// Ports   : req_if      in   fetch path requesting
//           req_ls      in   load/store path requesting
//           last_owner  in   requester served most recently
//           win_valid   out  at least one requester is asking
//           win         out  selected requester (meaningful when win_valid)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic       req_if,
  input  logic       req_ls,
  input  arb_owner_e last_owner,
  output logic       win_valid,
  output arb_owner_e win
);

  always_comb begin
    win_valid = req_if | req_ls;
    win       = OWN_IF;
    if (req_if && req_ls) begin
      // Contention: the side that did not go last gets the slot.
      win = (last_owner == OWN_IF) ? OWN_LS : OWN_IF;
    end else if (req_ls) begin
      win = OWN_LS;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module  : mem_arbiter
// Purpose : Shares one single-port memory between the instruction-fetch (IF)
//           and load/store (LS) paths. Round-robin grant, registered memory
//           side, variable-latency mem_ready handshake, read data and a
//           completion pulse returned to the owning requester.
// Config  : `define ARB_TIMEOUT_EN adds a BUSY watchdog that aborts an access
//           after TIMEOUT stalled cycles (err=1, rdata all-ones). Without it
//           err is tied low and BUSY waits indefinitely.
// Ports   : clk, rst                      clock, sync active-high reset
//           if_req/if_addr                fetch request and address
//           if_gnt/if_valid/if_rdata      fetch grant, completion, data
//           ls_req/ls_we/ls_addr/ls_wdata load/store request fields
//           ls_gnt/ls_valid/ls_rdata      load/store grant, completion, data
//           mem_en/mem_we/mem_addr/mem_wdata  registered memory command
//           mem_rdata/mem_ready           memory response
//           err                           abort flag alongside valid
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = ARB_DEF_AW,
  parameter int DW      = ARB_DEF_DW,
  parameter int TIMEOUT = ARB_DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  // instruction fetch
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  // load/store
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_valid,
  output logic [DW-1:0] ls_rdata,
  // memory
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          err
);

  if (TIMEOUT < 1) begin : g_timeout_guard
    $error("mem_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_e    state_q, state_d;
  arb_owner_e    owner_q, owner_d;
  arb_owner_e    last_owner_q, last_owner_d;

  logic          if_gnt_q, if_gnt_d;
  logic          ls_gnt_q, ls_gnt_d;
  logic          if_valid_q, if_valid_d;
  logic          ls_valid_q, ls_valid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] ls_rdata_q, ls_rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic          w_win_valid;
  arb_owner_e    w_win;
  logic          w_timeout;

`ifdef ARB_TIMEOUT_EN
  localparam int             CNT_W    = cnt_width(TIMEOUT);
  // The abort edge is the one that would bring the stall count to TIMEOUT,
  // so the access spends exactly TIMEOUT cycles in BUSY.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign w_timeout = (state_q == ST_BUSY) && !mem_ready && (cnt_q == CNT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  rr_pick2 u_pick (
    .req_if     (if_req),
    .req_ls     (ls_req),
    .last_owner (last_owner_q),
    .win_valid  (w_win_valid),
    .win        (w_win)
  );

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    if_gnt_d     = 1'b0;
    ls_gnt_d     = 1'b0;
    if_valid_d   = 1'b0;
    ls_valid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // mem_ready is deliberately not looked at here.
        if (w_win_valid) begin
          state_d      = ST_BUSY;
          owner_d      = w_win;
          last_owner_d = w_win;
          mem_en_d     = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
          if (w_win == OWN_LS) begin
            ls_gnt_d    = 1'b1;
            mem_we_d    = ls_we;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
          end else begin
            if_gnt_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end

      ST_BUSY: begin
        // A real completion on the timeout edge takes precedence, which
        // w_timeout already encodes by requiring mem_ready low.
        if (mem_ready || w_timeout) begin
          state_d  = ST_IDLE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (owner_q == OWN_LS) begin
            ls_valid_d = 1'b1;
          end else begin
            if_valid_d = 1'b1;
          end

          if (w_timeout) begin
`ifdef ARB_TIMEOUT_EN
            err_d = 1'b1;
`endif
            if (owner_q == OWN_LS) begin
              ls_rdata_d = '1;
            end else begin
              if_rdata_d = '1;
            end
          end else if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
          end else if (!mem_we_q) begin
            // Stores leave the previous load data in place.
            ls_rdata_d = mem_rdata;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_LS;
      if_gnt_q     <= 1'b0;
      ls_gnt_q     <= 1'b0;
      if_valid_q   <= 1'b0;
      ls_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      if_gnt_q     <= if_gnt_d;
      ls_gnt_q     <= ls_gnt_d;
      if_valid_q   <= if_valid_d;
      ls_valid_q   <= ls_valid_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign if_gnt    = if_gnt_q;
  assign ls_gnt    = ls_gnt_q;
  assign if_valid  = if_valid_q;
  assign ls_valid  = ls_valid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Self-checking bench for mem_arbiter. A small memory model answers
//           after a programmable number of BUSY cycles; expected completions
//           are queued when a request is driven and popped on each valid.
// Config  : timeout cases are included when ARB_TIMEOUT_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we, ls_gnt, ls_valid;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic          mem_en, mem_we, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit          own_ls;
    logic [15:0] rdata;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [0:255];
  bit          init_done = 1'b0;
  logic [15:0] exp_if_rd, exp_ls_rd;
  int          lat = 0;
  int          busy_cnt = 0;
  bit          idle_ready = 1'b0;

  // Memory model and completion scoreboard, both on the falling edge.
  always @(negedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) model[i] <= 16'(i * 16'h0101) ^ 16'h5A5A;
      model[4]  <= 16'hA23C;
      init_done <= 1'b1;
    end

    if (!rst && (if_valid || ls_valid)) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {30'b0, if_valid, ls_valid}, 32'h0);
      end else begin
        check("valid_owner", ls_valid, sb[0].own_ls);
        check("valid_onehot", if_valid & ls_valid, 1'b0);
        check("valid_rdata", sb[0].own_ls ? ls_rdata : if_rdata, sb[0].rdata);
        check("valid_err", err, sb[0].err);
        check("valid_mem_en_low", mem_en, 1'b0);
        sb.delete(0);
      end
    end
    if (!rst && err && !(if_valid || ls_valid)) check("err_without_valid", err, 1'b0);

    if (mem_en && !rst) begin
      if (busy_cnt == lat) begin
        mem_ready <= 1'b1;
        mem_rdata <= model[mem_addr[7:0]];
        if (mem_we) model[mem_addr[7:0]] <= mem_wdata;
      end else begin
        mem_ready <= 1'b0;
        mem_rdata <= 16'hDEAD;
      end
      busy_cnt <= busy_cnt + 1;
    end else begin
      mem_ready <= idle_ready;
      mem_rdata <= 16'hBEEF;
      busy_cnt  <= 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_check(input string tag);
    check({tag, "_flags"}, {25'b0, if_gnt, if_valid, ls_gnt, ls_valid, mem_en, mem_we, err}, 32'h0);
    check({tag, "_if_rdata"}, if_rdata, 16'h0);
    check({tag, "_ls_rdata"}, ls_rdata, 16'h0);
    check({tag, "_mem_addr"}, mem_addr, 16'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 16'h0);
  endtask

  // One request from an otherwise idle arbiter, followed to its completion.
  task automatic do_req(input bit ls, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, input int l, input int exp_busy,
                        input bit exp_err);
    exp_t        e;
    int          busy;
    logic [15:0] exp_wd;
    lat      = l;
    e.own_ls = ls;
    e.err    = exp_err;
    if (exp_err)       e.rdata = 16'hFFFF;
    else if (ls && we) e.rdata = exp_ls_rd;
    else               e.rdata = model[addr[7:0]];
    sb.push_back(e);
    if (ls) exp_ls_rd = e.rdata;
    else    exp_if_rd = e.rdata;
    exp_wd = ls ? wdata : 16'h0;

    if (ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    step();
    check("gnt_next_cycle", ls ? ls_gnt : if_gnt, 1'b1);
    check("gnt_other_low", ls ? if_gnt : ls_gnt, 1'b0);
    if_req = 1'b0;
    ls_req = 1'b0;

    busy = 0;
    while (!(ls ? ls_valid : if_valid) && busy < 200) begin
      check("busy_mem_en", mem_en, 1'b1);
      check("busy_mem_addr", mem_addr, addr);
      check("busy_mem_we", mem_we, ls & we);
      check("busy_mem_wdata", mem_wdata, exp_wd);
      if (busy > 0) check("gnt_one_cycle", ls ? ls_gnt : if_gnt, 1'b0);
      busy++;
      step();
    end
    check("busy_cycles", busy, exp_busy);
    check("valid_seen", ls ? ls_valid : if_valid, 1'b1);
    step();
    check("valid_one_cycle", ls ? ls_valid : if_valid, 1'b0);
  endtask

  initial begin
    int   w;
    exp_t e;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    exp_if_rd = '0; exp_ls_rd = '0;

    // Both requesters already high while reset drops.
    if_req = 1'b1; ls_req = 1'b1; if_addr = 16'h0020; ls_addr = 16'h0030;
    repeat (3) step();
    zero_check("reset");

    lat = 1;
    for (int g = 0; g < 4; g++) begin
      e.own_ls = g[0];
      e.err    = 1'b0;
      e.rdata  = g[0] ? model[8'h30] : model[8'h20];
      sb.push_back(e);
    end
    exp_if_rd = model[8'h20];
    exp_ls_rd = model[8'h30];
    rst = 1'b0;

    for (int g = 0; g < 4; g++) begin
      w = 0;
      do begin
        step();
        w++;
      end while (!(if_gnt || ls_gnt) && w < 20);
      check("contention_gnt_ls", ls_gnt, g[0]);
      check("contention_gnt_if", if_gnt, !g[0]);
      if (g == 0) check("first_gnt_latency", w, 1);
      else        check("gnt_spacing", w, 3);
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    for (int i = 0; i < 30 && sb.size() != 0; i++) step();
    check("contention_drain", sb.size(), 0);

    // mem_ready pulses while idle must not produce a completion.
    idle_ready = 1'b1;
    repeat (3) begin
      step();
      check("idle_ready_ignored", {if_valid, ls_valid, mem_en}, 3'b000);
    end
    idle_ready = 1'b0;
    step();

    // Single fetch: data back two cycles after the request.
    do_req(1'b0, 1'b0, 16'h0004, 16'h0, 0, 1, 1'b0);
    check("fetch_rdata", if_rdata, 16'hA23C);

    // Store with a 3-cycle stall, then read it back.
    do_req(1'b1, 1'b1, 16'h0010, 16'h1234, 3, 4, 1'b0);
    check("store_keeps_ls_rdata", ls_rdata, exp_ls_rd);
    do_req(1'b1, 1'b0, 16'h0010, 16'h0, 2, 3, 1'b0);
    check("store_readback", ls_rdata, 16'h1234);
    do_req(1'b0, 1'b0, 16'h0077, 16'h0, 5, 6, 1'b0);

    // Reset during a stalled access.
    lat = 1000;
    ls_we = 1'b0; ls_addr = 16'h0050; ls_req = 1'b1;
    step();
    check("rstmid_gnt", ls_gnt, 1'b1);
    ls_req = 1'b0;
    repeat (3) step();
    check("rstmid_busy", mem_en, 1'b1);
    rst = 1'b1;
    step();
    zero_check("rst_mid");
    rst = 1'b0;
    exp_if_rd = '0;
    exp_ls_rd = '0;
    repeat (4) begin
      step();
      check("rstmid_no_valid", {if_valid, ls_valid}, 2'b00);
    end

    do_req(1'b1, 1'b0, 16'h0033, 16'h0, 1, 2, 1'b0);

`ifdef ARB_TIMEOUT_EN
    do_req(1'b1, 1'b0, 16'h0040, 16'h0, 1000, TIMEOUT, 1'b1);
    check("timeout_rdata", ls_rdata, 16'hFFFF);
    do_req(1'b1, 1'b0, 16'h0040, 16'h0, TIMEOUT - 1, TIMEOUT, 1'b0);
`endif

    repeat (3) step();
    check("final_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port data/instruction memory between two requesters: the instruction-fetch path (IF) and the load/store path (LS) driven by microcode_fsm.
- Two-requester round-robin grant, registered memory-side signals, and a variable-latency memory handshake.
- Returns read data and a completion pulse to the owning requester.

Parameters:
- AW, 16, address width.
- DW, 16, data width (matches 16-bit instruction word).
- TIMEOUT, 15, BUSY-cycle limit before abort; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- if_req  input  1  fetch request; held until if_gnt.
- if_addr  input  AW  fetch address; sampled on grant.
- if_gnt  output  1  one-cycle grant pulse to IF.
- if_valid  output  1  one-cycle completion pulse to IF.
- if_rdata  output  DW  fetched word, valid while if_valid=1.
- ls_req  input  1  load/store request; held until ls_gnt.
- ls_we  input  1  1 = store, 0 = load.
- ls_addr  input  AW  load/store address.
- ls_wdata  input  DW  store data.
- ls_gnt  output  1  one-cycle grant pulse to LS.
- ls_valid  output  1  one-cycle completion pulse to LS.
- ls_rdata  output  DW  load data, valid while ls_valid=1.
- mem_en  output  1  memory access active.
- mem_we  output  1  memory write strobe, qualified by mem_en.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, sampled when mem_ready=1.
- mem_ready  input  1  memory completes the current access.
- err  output  1  abort flag, coincident with the valid pulse.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, last_owner=LS, and every output 0 (gnt, valid, rdata, mem_*, err).
- Reset asserted mid-transaction drops mem_en at the next edge. No valid pulse is issued for the aborted access.

States:
- IDLE: req sampled only here.
- BUSY: access in flight; all req ignored.

IDLE -> BUSY (edge where any req=1):
- If only one req is high, that requester wins.
- If both are high, the winner is the requester not equal to last_owner.
- At that edge:
  - owner <= winner; last_owner <= winner.
  - The winner's gnt <= 1 for exactly one cycle.
  - mem_en <= 1.
  - mem_addr, mem_we, mem_wdata <= winner's fields. IF access: mem_we=0, mem_wdata=0.

BUSY:
- mem_* held stable while mem_ready=0.

BUSY -> IDLE (edge where mem_ready=1):
- mem_en <= 0 and mem_we <= 0.
- Owner's valid <= 1 for one cycle.
- Owner's rdata <= mem_rdata, for reads only. On a store, ls_rdata keeps its previous value.

Timing:
- Req high in cycle N: gnt and mem_en high in N+1.
- mem_ready high in cycle M: valid high in M+1.
- Minimum latency req -> valid is 2 cycles.
- Next mem_en no earlier than M+2: one idle cycle between back-to-back accesses.

Protocol rules:
- Requesters deassert req in the cycle after gnt. A req still high in the valid cycle counts as a new request.
- Address and data only need to be stable in the cycle req is sampled; the arbiter registers them.
- mem_ready while IDLE is ignored.
- A requester whose req drops before grant is not served (no latching of lost requests).

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on IDLE -> BUSY and increments each BUSY cycle with mem_ready=0.
  - When it reaches TIMEOUT, the next edge forces BUSY -> IDLE: mem_en <= 0, owner valid <= 1, err <= 1 for that cycle, owner rdata <= all-ones.
  - mem_ready arriving on the same edge as the timeout wins: normal completion, err=0.
- Without the macro: err is tied 0, there is no counter, and BUSY waits indefinitely.

Decomposition:
- Shared header arb_defs.vh holds:
  - state encodings ST_IDLE=1'b0, ST_BUSY=1'b1;
  - owner encodings OWN_IF=1'b0, OWN_LS=1'b1.
- Sub-module rr_pick2 is natural: combinational two-way round-robin pick (inputs: req_if, req_ls, last_owner; outputs: win_valid, win).
- The rest (FSM, registers, timeout counter) lives in mem_arbiter.

Test Plan:
- Single fetch:
  - Stimulus: if_req=1, if_addr=16'h0004, mem_ready=1 in the first BUSY cycle, mem_rdata=16'hA23C.
  - Required: if_gnt at N+1, mem_en=1/mem_we=0/mem_addr=16'h0004 at N+1, if_valid=1 with if_rdata=16'hA23C at N+2.
- Store:
  - Stimulus: ls_req=1, ls_we=1, ls_addr=16'h0010, ls_wdata=16'h1234, mem_ready delayed 3 cycles.
  - Required: mem_we=1 and mem_wdata=16'h1234 held 3 cycles; ls_valid one cycle later; ls_rdata unchanged.
- Contention after reset:
  - Stimulus: both req high from the cycle rst drops.
  - Required: IF granted first, LS second; then keep both requesting and check grants alternate IF, LS, IF, LS.
- Reset mid-access:
  - Stimulus: assert rst during BUSY with mem_ready=0.
  - Required: next cycle mem_en=0, no valid pulse, all outputs 0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=15):
  - Stimulus: ls load with mem_ready held 0.
  - Required: after 15 BUSY cycles, ls_valid=1, err=1, ls_rdata=16'hFFFF.
  - Repeat with mem_ready=1 on the timeout edge: required err=0 and real data returned.
